// File: rtl/mips_pkg.sv
// Shared types and encodings for the MIPS multi-cycle control path:
// FSM states, opcode values, ALU-op and mux-select encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        RST,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        REXEC,
        RWB,
        IEXEC,
        IWB,
        BRANCH,
        JUMP,
        TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALUOP_NONE = 3'b000;
    localparam logic [2:0] ALUOP_FUNC = 3'b001;
    localparam logic [2:0] ALUOP_BR   = 3'b010;
    localparam logic [2:0] ALUOP_ADD  = 3'b100;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic is_lw;
        logic is_sw;
        logic is_rtype;
        logic is_itype;
        logic is_beq;
        logic is_bne;
        logic is_jump;
        logic is_illegal;
    } op_class_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Shared memory port between the control FSM (master) and the memory (slave).
interface mips_mc_control_if;

    logic mem_rd;
    logic mem_wr;
    logic iord;
    logic mem_ready;
    logic bus_err;

    modport master (
        output mem_rd,
        output mem_wr,
        output iord,
        output bus_err,
        input  mem_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  iord,
        input  bus_err,
        output mem_ready
    );

endinterface

// File: rtl/mips_opcode_class.sv
// Combinational opcode -> instruction class decode, one-hot over the
// supported classes with everything else flagged illegal.
module mips_opcode_class
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_LW:    cls.is_lw    = 1'b1;
            OP_SW:    cls.is_sw    = 1'b1;
            OP_RTYPE: cls.is_rtype = 1'b1;
            OP_BEQ:   cls.is_beq   = 1'b1;
            OP_BNE:   cls.is_bne   = 1'b1;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:
                      cls.is_itype = 1'b1;
            OP_J:     cls.is_jump  = 1'b1;
            default:  cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle main control FSM for the MIPS stub datapath.
// Optional: define MIPS_ILLEGAL_TRAP_EN to lock into TRAP on unsupported opcodes.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_mc_control_if.master  mem,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               ir_write,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [5:0]         alu_f,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal
);

    // Count value seen during the MEM_TIMEOUT-th consecutive wait cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wait_cnt;
    logic            waiting;
    logic            timeout;
    op_class_t       cls;

    mips_opcode_class u_opcode_class (
        .opcode (opcode),
        .cls    (cls)
    );

    assign waiting = ((state == FETCH) || (state == MEMRD) || (state == MEMWR))
                     && !mem.mem_ready;
    assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TO_LAST);

    // A FETCH timeout keeps the state unchanged, so the retry clears explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || timeout)
                wait_cnt <= '0;
            else if (waiting && (wait_cnt != '1))
                wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST:    state_nxt = FETCH;
            FETCH: begin
                if (mem.mem_ready)
                    state_nxt = DECODE;
                else if (timeout)
                    state_nxt = FETCH;
            end
            DECODE: begin
                if (cls.is_lw || cls.is_sw)
                    state_nxt = MEMADR;
                else if (cls.is_rtype)
                    state_nxt = REXEC;
                else if (cls.is_beq || cls.is_bne)
                    state_nxt = BRANCH;
                else if (cls.is_itype)
                    state_nxt = IEXEC;
                else if (cls.is_jump)
                    state_nxt = JUMP;
                else
`ifdef MIPS_ILLEGAL_TRAP_EN
                    state_nxt = TRAP;
`else
                    state_nxt = FETCH;
`endif
            end
            MEMADR: state_nxt = cls.is_lw ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem.mem_ready)
                    state_nxt = MEMWB;
                else if (timeout)
                    state_nxt = FETCH;
            end
            MEMWR: begin
                if (mem.mem_ready || timeout)
                    state_nxt = FETCH;
            end
            MEMWB:  state_nxt = FETCH;
            REXEC:  state_nxt = RWB;
            RWB:    state_nxt = FETCH;
            IEXEC:  state_nxt = IWB;
            IWB:    state_nxt = FETCH;
            BRANCH: state_nxt = FETCH;
            JUMP:   state_nxt = FETCH;
            TRAP:   state_nxt = TRAP;
            default: state_nxt = RST;
        endcase
    end

    always_comb begin
        mem.mem_rd = 1'b0;
        mem.mem_wr = 1'b0;
        mem.iord   = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_RT;
        alu_op     = ALUOP_NONE;
        alu_f      = '0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem.mem_rd = 1'b1;
                alu_src_b  = ALUB_FOUR;
                alu_op     = ALUOP_ADD;
                ir_write   = mem.mem_ready;
                pc_en      = mem.mem_ready;
            end
            DECODE: begin
                alu_src_b = ALUB_IMM_SH;
                alu_op    = ALUOP_ADD;
`ifndef MIPS_ILLEGAL_TRAP_EN
                illegal   = cls.is_illegal;
`endif
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                mem.mem_rd = 1'b1;
                mem.iord   = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem.mem_wr = 1'b1;
                mem.iord   = 1'b1;
            end
            REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNC;
                alu_f     = funct;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_op    = ALUOP_FUNC;
                alu_f     = funct;
            end
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALUOP_FUNC;
                alu_f     = opcode;
            end
            IWB:    reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_BR;
                alu_f     = opcode;
                pc_src    = PCSRC_ALUOUT;
                pc_en     = cls.is_bne ? !zero : zero;
            end
            JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
            end
            TRAP:   illegal = 1'b1;
            default: ;
        endcase
    end

    assign mem.bus_err = timeout;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed per-cycle vectors for mips_mc_control; expected outputs are
// queued by the driver and checked by an independent monitor on negedge.
module tb_mips_mc_control;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       bus_err;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [5:0] alu_f;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [5:0] alu_f;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;

    mips_mc_control_if bus ();

    mips_mc_control #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .alu_f      (alu_f),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    outs_t       exp_q[$];
    string       name_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [5:0]  cur_op;
    logic [5:0]  cur_fn;
    outs_t       mon_exp;
    outs_t       mon_act;
    string       mon_name;

    function automatic outs_t e_zero();
        return '0;
    endfunction

    function automatic outs_t e_fetch(input logic rdy, input logic berr);
        outs_t o = '0;
        o.mem_rd = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 3'b100;
        o.ir_write = rdy; o.pc_en = rdy; o.bus_err = berr;
        return o;
    endfunction

    function automatic outs_t e_decode(input logic ill);
        outs_t o = '0;
        o.alu_src_b = 2'b11; o.alu_op = 3'b100; o.illegal = ill;
        return o;
    endfunction

    function automatic outs_t e_memadr();
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b100;
        return o;
    endfunction

    function automatic outs_t e_memrd();
        outs_t o = '0;
        o.mem_rd = 1'b1; o.iord = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_memwr(input logic berr);
        outs_t o = '0;
        o.mem_wr = 1'b1; o.iord = 1'b1; o.bus_err = berr;
        return o;
    endfunction

    function automatic outs_t e_memwb();
        outs_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_rexec(input logic [5:0] f);
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.alu_f = f;
        return o;
    endfunction

    function automatic outs_t e_rwb(input logic [5:0] f);
        outs_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = 1'b1; o.alu_op = 3'b001; o.alu_f = f;
        return o;
    endfunction

    function automatic outs_t e_iexec(input logic [5:0] op);
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b001; o.alu_f = op;
        return o;
    endfunction

    function automatic outs_t e_iwb();
        outs_t o = '0;
        o.reg_write = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_branch(input logic [5:0] op, input logic pcen);
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 3'b010; o.alu_f = op;
        o.pc_src = 2'b01; o.pc_en = pcen;
        return o;
    endfunction

    function automatic outs_t e_jump();
        outs_t o = '0;
        o.pc_src = 2'b10; o.pc_en = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_trap();
        outs_t o = '0;
        o.illegal = 1'b1;
        return o;
    endfunction

    // One clock cycle: drive inputs just after the edge, queue the expected outputs.
    task automatic step(input logic rst, input logic z, input logic rdy,
                        input outs_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n         = rst;
        zero          = z;
        bus.mem_ready = rdy;
        opcode        = cur_op;
        funct         = cur_fn;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act.mem_rd     = bus.mem_rd;
                mon_act.mem_wr     = bus.mem_wr;
                mon_act.iord       = bus.iord;
                mon_act.bus_err    = bus.bus_err;
                mon_act.ir_write   = ir_write;
                mon_act.pc_en      = pc_en;
                mon_act.pc_src     = pc_src;
                mon_act.alu_src_a  = alu_src_a;
                mon_act.alu_src_b  = alu_src_b;
                mon_act.alu_op     = alu_op;
                mon_act.alu_f      = alu_f;
                mon_act.reg_write  = reg_write;
                mon_act.reg_dst    = reg_dst;
                mon_act.mem_to_reg = mem_to_reg;
                mon_act.illegal    = illegal;
                vectors++;
                if (mon_act !== mon_exp) begin
                    miscompares++;
                    $display("FAIL %s: got %b required %b", mon_name, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        zero          = 1'b0;
        bus.mem_ready = 1'b0;
        cur_op        = 6'b000000;
        cur_fn        = 6'b100000;
        opcode        = cur_op;
        funct         = cur_fn;

        step(1'b0, 1'b0, 1'b0, e_zero(), "reset");
        step(1'b1, 1'b0, 1'b0, e_zero(), "rst_release");

        // add: 4 cycles
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "add_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "add_decode");
        step(1'b1, 1'b0, 1'b1, e_rexec(6'b100000), "add_rexec");
        step(1'b1, 1'b0, 1'b1, e_rwb(6'b100000), "add_rwb");

        // lw with 3 wait cycles; ready arrives exactly at the timeout count
        cur_op = 6'b100011; cur_fn = 6'b000000;
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "lw_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "lw_decode");
        step(1'b1, 1'b0, 1'b0, e_memadr(), "lw_memadr");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, e_memrd(), "lw_memrd_wait");
        step(1'b1, 1'b0, 1'b1, e_memrd(), "lw_memrd_done");
        step(1'b1, 1'b0, 1'b0, e_memwb(), "lw_memwb");

        // beq taken / not taken, bne taken
        cur_op = 6'b000100;
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "beq1_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "beq1_decode");
        step(1'b1, 1'b1, 1'b1, e_branch(6'b000100, 1'b1), "beq_zero1");
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "beq2_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "beq2_decode");
        step(1'b1, 1'b0, 1'b1, e_branch(6'b000100, 1'b0), "beq_zero0");
        cur_op = 6'b000101;
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "bne_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "bne_decode");
        step(1'b1, 1'b0, 1'b1, e_branch(6'b000101, 1'b1), "bne_zero0");

        // sw with mem_ready stuck low: bus_err on the 4th wait cycle
        cur_op = 6'b101011;
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "sw_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "sw_decode");
        step(1'b1, 1'b0, 1'b0, e_memadr(), "sw_memadr");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, e_memwr(1'b0), "sw_memwr_wait");
        step(1'b1, 1'b0, 1'b0, e_memwr(1'b1), "sw_timeout");

        // fetch timeout then retry with a freshly cleared counter
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "fetch_wait");
        step(1'b1, 1'b0, 1'b0, e_fetch(1'b0, 1'b1), "fetch_timeout");
        cur_op = 6'b001101;
        step(1'b1, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "fetch_retry_wait");
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "ori_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "ori_decode");
        step(1'b1, 1'b0, 1'b1, e_iexec(6'b001101), "ori_iexec");
        step(1'b1, 1'b0, 1'b1, e_iwb(), "ori_iwb");

        cur_op = 6'b000010;
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "j_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "j_decode");
        step(1'b1, 1'b0, 1'b1, e_jump(), "j_jump");

        cur_op = 6'b111111;
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "ill_fetch");
`ifdef MIPS_ILLEGAL_TRAP_EN
        step(1'b1, 1'b0, 1'b0, e_decode(1'b0), "ill_decode");
        step(1'b1, 1'b0, 1'b0, e_trap(), "ill_trap1");
        step(1'b1, 1'b0, 1'b0, e_trap(), "ill_trap2");
`else
        step(1'b1, 1'b0, 1'b0, e_decode(1'b1), "ill_decode");
        step(1'b1, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "ill_next_fetch1");
        step(1'b1, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "ill_next_fetch2");
`endif
        step(1'b0, 1'b0, 1'b0, e_zero(), "rst_mid");
        step(1'b1, 1'b0, 1'b0, e_zero(), "rst_release2");

        // reset asserted while MEMRD waits drops mem_rd within the cycle
        cur_op = 6'b100011;
        step(1'b1, 1'b0, 1'b1, e_fetch(1'b1, 1'b0), "lw2_fetch");
        step(1'b1, 1'b0, 1'b1, e_decode(1'b0), "lw2_decode");
        step(1'b1, 1'b0, 1'b0, e_memadr(), "lw2_memadr");
        step(1'b1, 1'b0, 1'b0, e_memrd(), "lw2_memrd_wait");
        step(1'b0, 1'b0, 1'b0, e_zero(), "rst_in_memrd");
        step(1'b1, 1'b0, 1'b0, e_zero(), "rst_release3");
        step(1'b1, 1'b0, 1'b0, e_fetch(1'b0, 1'b0), "fetch_after_rst");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
